// File: rtl/digit_bbox_detect.sv
// digit_bbox_detect: binarizes an RGB pixel stream and reports the per-frame foreground bounding box
// Ports: Clk/Rst (async active-high) clock and reset; pix_valid, H_Addr, V_Addr, RED/GREEN/BLUE pixel input;
//        bin_valid/bin_pixel binarized stream (2-cycle latency); bbox_valid one-cycle frame-end pulse with
//        bbox_found, x_min/x_max/y_min/y_max and fg_count held until the next pulse.
module digit_bbox_detect #(
  parameter int         IMAGE_WIDTH  = 1920,
  parameter int         IMAGE_HEIGHT = 1080,
  parameter logic [7:0] THRESHOLD    = 8'd100,
  parameter bit         INVERT       = 1'b1,
  parameter int         MIN_PIXELS   = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        pix_valid,
  input  logic [11:0] H_Addr,
  input  logic [11:0] V_Addr,
  input  logic [7:0]  RED,
  input  logic [7:0]  GREEN,
  input  logic [7:0]  BLUE,
  output logic        bin_valid,
  output logic        bin_pixel,
  output logic        bbox_valid,
  output logic        bbox_found,
  output logic [11:0] x_min,
  output logic [11:0] x_max,
  output logic [11:0] y_min,
  output logic [11:0] y_max,
  output logic [21:0] fg_count
);
  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  ACCUM  = 1'b1;
  localparam logic [11:0] X_LAST = 12'(IMAGE_WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(IMAGE_HEIGHT - 1);
  logic [15:0] w_sum;
  logic [7:0]  r_gray;
  logic        r_v1;
  logic [11:0] r_x1, r_y1, r_x2, r_y2;
  logic [0:0]  r_state;
  logic [11:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [21:0] r_cnt;
  logic        w_fg, w_start, w_upd, w_last, w_found;
  logic [11:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic [21:0] w_cnt;
  assign w_sum = 16'd77 * {8'd0, RED} + 16'd150 * {8'd0, GREEN} + 16'd29 * {8'd0, BLUE};
  assign w_fg = INVERT ? (r_gray < THRESHOLD) : (r_gray >= THRESHOLD);
  // A valid (0,0) pixel in stage 2 always (re)starts a frame, even mid-frame.
  assign w_start = bin_valid && r_x2 == 12'd0 && r_y2 == 12'd0;
  assign w_upd = r_state == ACCUM && !w_start && bin_valid && bin_pixel &&
                 {1'b0, r_x2} < 13'(IMAGE_WIDTH) && {1'b0, r_y2} < 13'(IMAGE_HEIGHT);
  assign w_last = r_state == ACCUM && !w_start && bin_valid && r_x2 == X_LAST && r_y2 == Y_LAST;
  // Next accumulator values; frame-end results are taken from these so the last pixel is included.
  assign w_xmin = w_start ? (bin_pixel ? 12'd0 : 12'hFFF) : (w_upd && r_x2 < r_xmin) ? r_x2 : r_xmin;
  assign w_ymin = w_start ? (bin_pixel ? 12'd0 : 12'hFFF) : (w_upd && r_y2 < r_ymin) ? r_y2 : r_ymin;
  assign w_xmax = w_start ? 12'd0 : (w_upd && r_x2 > r_xmax) ? r_x2 : r_xmax;
  assign w_ymax = w_start ? 12'd0 : (w_upd && r_y2 > r_ymax) ? r_y2 : r_ymax;
  assign w_cnt = w_start ? {21'd0, bin_pixel} : r_cnt + {21'd0, w_upd};
  assign w_found = w_cnt >= 22'(MIN_PIXELS);
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_gray     <= '0;
      r_v1       <= 1'b0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      bin_valid  <= 1'b0;
      bin_pixel  <= 1'b0;
      r_state    <= IDLE;
      r_xmin     <= 12'hFFF;
      r_ymin     <= 12'hFFF;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_cnt      <= '0;
      bbox_valid <= 1'b0;
      bbox_found <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      fg_count   <= '0;
    end else begin
      r_gray     <= 8'(w_sum >> 8);
      r_v1       <= pix_valid;
      r_x1       <= H_Addr;
      r_y1       <= V_Addr;
      r_x2       <= r_x1;
      r_y2       <= r_y1;
      bin_valid  <= r_v1;
      bin_pixel  <= r_v1 && w_fg;
      r_state    <= w_start ? ACCUM : w_last ? IDLE : r_state;
      r_xmin     <= w_xmin;
      r_ymin     <= w_ymin;
      r_xmax     <= w_xmax;
      r_ymax     <= w_ymax;
      r_cnt      <= w_cnt;
      bbox_valid <= w_last;
      if (w_last) begin
        bbox_found <= w_found;
        x_min      <= w_found ? w_xmin : 12'd0;
        x_max      <= w_found ? w_xmax : 12'd0;
        y_min      <= w_found ? w_ymin : 12'd0;
        y_max      <= w_found ? w_ymax : 12'd0;
        fg_count   <= w_cnt;
      end
    end
endmodule

// File: tb/tb_digit_bbox_detect.sv
// tb_digit_bbox_detect: randomized and directed frames checked against a whole-image reference model
module tb_digit_bbox_detect;
  localparam int W = 16;
  localparam int H = 8;
  localparam int MINP = 4;
  logic        Clk = 1'b0, Rst = 1'b0, pix_valid = 1'b0;
  logic [11:0] H_Addr = '0, V_Addr = '0;
  logic [7:0]  RED = '0, GREEN = '0, BLUE = '0;
  logic        bin_valid, bin_pixel, bbox_valid, bbox_found;
  logic [11:0] x_min, x_max, y_min, y_max;
  logic [21:0] fg_count;
  int errors = 0, checks = 0, cyc = 0, n_pulse = 0, pulse_cyc = 0, last_cyc = 0;
  int ir[H][W], ig[H][W], ib[H][W];
  typedef struct {bit fg; int cyc;} exp_t;
  exp_t q[$];

  digit_bbox_detect #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(8'd100), .INVERT(1'b1), .MIN_PIXELS(MINP)) dut (
    .Clk(Clk), .Rst(Rst), .pix_valid(pix_valid), .H_Addr(H_Addr), .V_Addr(V_Addr),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .bin_valid(bin_valid), .bin_pixel(bin_pixel),
    .bbox_valid(bbox_valid), .bbox_found(bbox_found), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .fg_count(fg_count));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_fg(input int r, input int g, input int b);
    return ((77 * r + 150 * g + 29 * b) / 256) < 100;
  endfunction

  always @(negedge Clk) begin : mon
    exp_t e;
    if (!Rst) begin
      if (bin_valid) begin
        if (q.size() == 0) chk("bin_extra", 1, 0);
        else begin
          e = q.pop_front();
          chk("bin_pixel", bin_pixel, e.fg);
          chk("bin_latency", cyc - e.cyc, 2);
        end
      end else chk("bin_idle", bin_pixel, 0);
      if (bbox_valid) begin
        n_pulse++;
        pulse_cyc = cyc;
      end
    end
  end

  task automatic drive(input bit v, input int x, input int y, input int r, input int g, input int b);
    exp_t e;
    @(posedge Clk);
    #1;
    pix_valid = v;
    H_Addr = 12'(x);
    V_Addr = 12'(y);
    RED = 8'(r);
    GREEN = 8'(g);
    BLUE = 8'(b);
    if (v) begin
      e.fg = is_fg(r, g, b);
      e.cyc = cyc;
      q.push_back(e);
      if (x == W - 1 && y == H - 1) last_cyc = cyc;
    end
  endtask

  task automatic set_pix(input int x, input int y, input int v);
    ir[y][x] = v;
    ig[y][x] = v;
    ib[y][x] = v;
  endtask

  task automatic fill_white();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) set_pix(x, y, 255);
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        ir[y][x] = $urandom_range(0, 255);
        ig[y][x] = $urandom_range(0, 255);
        ib[y][x] = $urandom_range(0, 255);
      end
  endtask

  task automatic send_rows(input int y0, input int y1, input bit gaps, input bit oor);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gaps && $urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) drive(0, $urandom_range(0, 20), $urandom_range(0, 10), 0, 0, 0);
        drive(1, x, y, ir[y][x], ig[y][x], ib[y][x]);
      end
      if (oor && y < H - 1) begin
        drive(1, W + 1, y, 0, 0, 0);
        drive(1, 2, H + 1, 0, 0, 0);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "/flags"}, {28'd0, bin_valid, bin_pixel, bbox_valid, bbox_found}, 0);
    chk({tag, "/x"}, {8'd0, x_min, x_max}, 0);
    chk({tag, "/y"}, {8'd0, y_min, y_max}, 0);
    chk({tag, "/count"}, {10'd0, fg_count}, 0);
  endtask

  task automatic run_frame(input string name, input bit gaps, input bit oor);
    int n0, cnt, xn, xx, yn, yx;
    bit found;
    n0 = n_pulse;
    cnt = 0; xn = 4095; xx = 0; yn = 4095; yx = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (is_fg(ir[y][x], ig[y][x], ib[y][x])) begin
          cnt++;
          xn = x < xn ? x : xn;
          xx = x > xx ? x : xx;
          yn = y < yn ? y : yn;
          yx = y > yx ? y : yx;
        end
    found = cnt >= MINP;
    send_rows(0, H - 1, gaps, oor);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && n_pulse == n0; i++) begin
      @(negedge Clk);
      #1;
    end
    chk({name, "/pulses"}, n_pulse - n0, 1);
    chk({name, "/pulse_delay"}, pulse_cyc - last_cyc, 3);
    chk({name, "/found"}, bbox_found, found);
    chk({name, "/fg_count"}, fg_count, cnt);
    chk({name, "/x_min"}, x_min, found ? xn : 0);
    chk({name, "/x_max"}, x_max, found ? xx : 0);
    chk({name, "/y_min"}, y_min, found ? yn : 0);
    chk({name, "/y_max"}, y_max, found ? yx : 0);
    @(posedge Clk);
    #2;
    chk({name, "/single_pulse"}, bbox_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    #2 Rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    fill_white();
    run_frame("white", 0, 0);
    fill_white();
    for (int y = 2; y <= 5; y++) for (int x = 3; x <= 9; x++) set_pix(x, y, 0);
    run_frame("rect", 0, 0);
    fill_white();
    set_pix(1, 0, 99);
    set_pix(2, 0, 100);
    set_pix(3, 0, 103);
    ir[0][4] = 98; ig[0][4] = 100; ib[0][4] = 100;
    run_frame("gray", 0, 0);
    fill_white();
    set_pix(1, 1, 0);
    set_pix(5, 3, 0);
    set_pix(10, 6, 0);
    run_frame("three", 0, 0);
    set_pix(15, 7, 0);
    run_frame("four", 0, 0);
    fill_random();
    set_pix(0, 0, 0);
    run_frame("rand", 0, 0);
    run_frame("rand_gaps", 1, 1);
    fill_random();
    set_pix(0, 0, 255);
    run_frame("rand2_gaps", 1, 1);
    fill_random();
    n0 = n_pulse;
    send_rows(0, 3, 0, 0);
    chk("abort/no_pulse", n_pulse, n0);
    fill_white();
    for (int y = 2; y <= 5; y++) for (int x = 3; x <= 9; x++) set_pix(x, y, 0);
    run_frame("after_abort", 0, 0);
    fill_random();
    send_rows(0, 3, 0, 0);
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    pix_valid = 1'b0;
    #1 check_zero("mid_reset");
    q.delete();
    @(posedge Clk);
    #1 Rst = 1'b0;
    n0 = n_pulse;
    send_rows(4, H - 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge Clk);
    #1 chk("mid_reset/no_pulse", n_pulse, n0);
    fill_white();
    set_pix(2, 1, 0);
    set_pix(7, 4, 0);
    set_pix(12, 2, 0);
    set_pix(4, 6, 0);
    run_frame("after_reset", 0, 0);
    repeat (4) @(posedge Clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
